time_report_ctrl: RTL and testbench
===================================

// Module: time_report_ctrl
// PURPOSE
//  Controller sequencing the UART timekeeper: generates its 1 Hz advance pulse from the system clock,
//  snapshots the time fields and streams them as a byte frame to the UART transmitter byte interface.
//  A frame is sent on every second tick when report_en=1, and on demand via req.
// PARAMETERS
//  CLK_HZ   50_000_000  system clock cycles per tick; prescaler period (>=2)
//  HEADER   8'hA5       first byte of every frame
// PORTS
//  clk_time   in   1  system clock; all state on posedge clk_time
//  reset      in   1  asynchronous, active-high reset
//  report_en  in   1  1: each tick triggers a frame
//  req        in   1  one-cycle pulse: request a frame now
//  sec_i      in   7  seconds from timekeeper
//  min_i      in   7  minutes from timekeeper
//  hour_i     in   6  hours from timekeeper
//  day_i      in   6  days from timekeeper
//  month_i    in   5  months from timekeeper
//  tick       out  1  one-cycle pulse every CLK_HZ cycles; drives timekeeper advance
//  tx_data    out  8  frame byte
//  tx_valid   out  1  tx_data valid
//  tx_ready   in   1  transmitter accepts byte when tx_valid&tx_ready
//  busy       out  1  1 while state != IDLE
//  overrun    out  1  one-cycle pulse: trigger dropped (pending already set)
// BEHAVIOUR
//  Reset (async): presc cnt=0, state=IDLE, pending=0; tick=0, tx_valid=0, tx_data=0, busy=0, overrun=0.
//  Prescaler: cnt 0..CLK_HZ-1, width $clog2(CLK_HZ); tick=1 when cnt==CLK_HZ-1, then cnt wraps to 0.
//    First tick is the CLK_HZ-th cycle after reset release.
//  trig = req | (tick & report_en); same-cycle req and tick = one trigger.
//  FSM: IDLE, SEND.
//   IDLE: if trig|pending -> snapshot fields (values present this cycle, i.e. pre-increment on a tick
//     cycle), idx=0, pending=0, -> SEND. tx_valid=1 with byte 0 on the next cycle (1-cycle latency).
//   SEND: byte idx presented; on tx_valid&tx_ready idx++. Last byte accepted -> IDLE, tx_valid=0.
//  Frame bytes (fields zero-extended to 8 bits): HEADER, month, day, hour, min, sec [, csum].
//  Handshake: tx_data/tx_valid held stable while tx_valid&!tx_ready; no valid drop without accept.
//  Triggers in SEND (incl. cycle of last accept): pending=0 -> pending=1; pending=1 -> overrun pulse,
//    trigger discarded. Pending frame launches from IDLE: exactly one idle cycle between frames.
//  Snapshot frozen for the whole frame; field changes during SEND do not affect bytes.
//  Reset mid-frame: frame abandoned, outputs to reset values immediately; no resume after release.
// CONFIGURATION
//  TIME_REPORT_CSUM_EN defined: frame = 7 bytes; byte 6 = XOR of bytes 0..5.
//  Undefined: frame = 6 bytes; no checksum logic.
// STRUCTURE
//  time_report_pkg.vh (shared package/include): state encodings, FRAME_LEN (6/7 by macro),
//    byte-index constants, default HEADER.
//  Sub-module tick_prescaler (CLK_HZ): cnt + tick. FSM, snapshot, byte mux in top.
// TESTING (bench uses CLK_HZ=8; csum checks only with TIME_REPORT_CSUM_EN)
//  Reset release, report_en=0, 20 cycles -> tick on cycles 8 and 16 only; tx_valid stays 0.
//  req pulse, sec=5 min=10 hour=3 day=7 month=2, tx_ready=1 -> A5,02,07,03,0A,05[,AC], 1 byte/cycle.
//  Same frame, tx_ready=0 for 3 cycles at byte 2 -> tx_data=07, tx_valid=1 held; resumes cleanly.
//  req in SEND, then second req in SEND -> one overrun pulse; exactly one extra frame, 1 idle cycle gap.
//  Reset asserted after byte 2 accepted -> tx_valid=0, busy=0 immediately; no bytes after release.
//  report_en=1, tx_ready=1 -> frame starts cycle after each tick; bytes equal fields at tick cycle.

Source files
------------

// File: rtl/time_report_ctrl_pkg.sv
// time_report_ctrl_pkg: shared types and frame layout for the time report controller.
// Frame length follows TIME_REPORT_CSUM_EN (7 bytes with trailing XOR checksum, else 6).
package time_report_ctrl_pkg;

    typedef enum logic {IDLE, SEND} state_t;

`ifdef TIME_REPORT_CSUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif

    localparam int IDX_W = 3;

    localparam logic [IDX_W-1:0] BYTE_HEADER = 3'd0;
    localparam logic [IDX_W-1:0] BYTE_MONTH  = 3'd1;
    localparam logic [IDX_W-1:0] BYTE_DAY    = 3'd2;
    localparam logic [IDX_W-1:0] BYTE_HOUR   = 3'd3;
    localparam logic [IDX_W-1:0] BYTE_MIN    = 3'd4;
    localparam logic [IDX_W-1:0] BYTE_SEC    = 3'd5;
    localparam logic [IDX_W-1:0] BYTE_CSUM   = 3'd6;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    typedef struct packed {
        logic [4:0] month;
        logic [5:0] day;
        logic [5:0] hour;
        logic [6:0] min;
        logic [6:0] sec;
    } snap_t;

`ifdef TIME_REPORT_CSUM_EN
    function automatic logic [7:0] frame_csum(logic [7:0] header, snap_t s);
        return header ^ {3'b0, s.month} ^ {2'b0, s.day} ^ {2'b0, s.hour}
                      ^ {1'b0, s.min} ^ {1'b0, s.sec};
    endfunction
`endif

endpackage

// File: rtl/time_report_ctrl_if.sv
// time_report_ctrl_if: byte stream toward the UART transmitter (valid/ready handshake).
interface time_report_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/time_report_ctrl_tick_prescaler.sv
// tick_prescaler: divides the system clock down to a one-cycle tick every CLK_HZ cycles.
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk_time,
    input  logic reset,
    output logic tick
);
    localparam int W = $clog2(CLK_HZ);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(CLK_HZ - 1);

    always_ff @(posedge clk_time or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/time_report_ctrl.sv
// time_report_ctrl: drives the timekeeper tick and streams snapshotted time fields as a byte frame.
// Optional checksum byte enabled by TIME_REPORT_CSUM_EN.
module time_report_ctrl
    import time_report_ctrl_pkg::*;
#(
    parameter int         CLK_HZ = 50_000_000,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic                       clk_time,
    input  logic                       reset,
    input  logic                       report_en,
    input  logic                       req,
    input  logic [6:0]                 sec_i,
    input  logic [6:0]                 min_i,
    input  logic [5:0]                 hour_i,
    input  logic [5:0]                 day_i,
    input  logic [4:0]                 month_i,
    output logic                       tick,
    time_report_ctrl_if.master         tx,
    output logic                       busy,
    output logic                       overrun
);
    state_t           state;
    snap_t            snap;
    logic             pending;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nidx;
    logic [7:0]       next_byte;
    logic             trig;
    logic             last;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
        .clk_time(clk_time),
        .reset   (reset),
        .tick    (tick)
    );

    assign trig = req | (tick & report_en);
    assign last = idx == IDX_W'(FRAME_LEN - 1);

    // Byte following the one currently presented, taken from the frozen snapshot
    always_comb begin
        nidx      = idx + 1'b1;
        next_byte = nidx == BYTE_MONTH ? {3'b0, snap.month} :
                    nidx == BYTE_DAY   ? {2'b0, snap.day}   :
                    nidx == BYTE_HOUR  ? {2'b0, snap.hour}  :
                    nidx == BYTE_MIN   ? {1'b0, snap.min}   :
                    nidx == BYTE_SEC   ? {1'b0, snap.sec}   :
`ifdef TIME_REPORT_CSUM_EN
                    nidx == BYTE_CSUM  ? frame_csum(HEADER, snap) :
`endif
                    HEADER;
    end

    always_ff @(posedge clk_time or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            snap        <= '0;
            pending     <= 1'b0;
            idx         <= BYTE_HEADER;
            tx.tx_valid <= 1'b0;
            tx.tx_data  <= 8'h00;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (state == IDLE) begin
                if (trig | pending) begin
                    snap        <= '{month: month_i, day: day_i, hour: hour_i, min: min_i, sec: sec_i};
                    idx         <= BYTE_HEADER;
                    pending     <= 1'b0;
                    state       <= SEND;
                    tx.tx_valid <= 1'b1;
                    tx.tx_data  <= HEADER;
                    busy        <= 1'b1;
                end
            end else begin
                // Only one trigger can be queued behind the frame in flight
                if (trig) begin
                    pending <= 1'b1;
                    overrun <= pending;
                end
                if (tx.tx_ready) begin
                    if (last) begin
                        state       <= IDLE;
                        tx.tx_valid <= 1'b0;
                        busy        <= 1'b0;
                    end else begin
                        idx        <= nidx;
                        tx.tx_data <= next_byte;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_time_report_ctrl.sv
// tb_time_report_ctrl: directed bench with a queue-based frame model checked every cycle.
module tb_time_report_ctrl;
    import time_report_ctrl_pkg::*;

    localparam int CLK_HZ = 8;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0, reset = 1'b1, report_en = 1'b0, req = 1'b0;
    logic [6:0] sec_i = '0, min_i = '0;
    logic [5:0] hour_i = '0, day_i = '0;
    logic [4:0] month_i = '0;
    logic tick, busy, overrun;

    time_report_ctrl_if bus();

    time_report_ctrl #(.CLK_HZ(CLK_HZ)) dut (
        .clk_time (clk),
        .reset    (reset),
        .report_en(report_en),
        .req      (req),
        .sec_i    (sec_i),
        .min_i    (min_i),
        .hour_i   (hour_i),
        .day_i    (day_i),
        .month_i  (month_i),
        .tick     (tick),
        .tx       (bus),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int   pass_cnt = 0, total = 0, cyc = 0, ov_cnt = 0;
    logic run = 1'b0;
    bq_t  acc;
    int   acc_c[$];

    // Reference frames worked out by hand
    logic [7:0] ref1 [7] = '{8'hA5, 8'h02, 8'h07, 8'h03, 8'h0A, 8'h05, 8'hAC};
    logic [7:0] ref2 [7] = '{8'hA5, 8'h06, 8'h0F, 8'h0C, 8'h1E, 8'h14, 8'hAA};
    logic [7:0] ref3 [7] = '{8'hA5, 8'h06, 8'h0F, 8'h0C, 8'h1E, 8'h15, 8'hAB};

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    endtask

    function automatic bq_t frame_of(int s, int m, int h, int d, int mo);
        bq_t f;
        logic [7:0] x;
        f.push_back(8'hA5);
        f.push_back(8'(mo));
        f.push_back(8'(d));
        f.push_back(8'(h));
        f.push_back(8'(m));
        f.push_back(8'(s));
`ifdef TIME_REPORT_CSUM_EN
        x = 8'h00;
        foreach (f[i]) x ^= f[i];
        f.push_back(x);
`endif
        return f;
    endfunction

    // Model: mq holds the bytes still to be shown for the frame in flight
    bq_t  mq;
    logic m_pend = 1'b0, m_ov = 1'b0, m_trig;
    int   m_cyc = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_pend = 1'b0;
            m_ov   = 1'b0;
            m_cyc  = 0;
        end else begin
            m_trig = req | (((m_cyc % CLK_HZ) == CLK_HZ - 1) & report_en);
            m_ov   = 1'b0;
            if (mq.size() != 0) begin
                if (bus.tx_ready) void'(mq.pop_front());
                if (m_trig) begin
                    if (m_pend) m_ov = 1'b1;
                    else        m_pend = 1'b1;
                end
            end else if (m_trig || m_pend) begin
                mq     = frame_of(sec_i, min_i, hour_i, day_i, month_i);
                m_pend = 1'b0;
            end
            m_cyc++;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (run) begin
            chk("tick", tick, int'((m_cyc % CLK_HZ) == CLK_HZ - 1));
            chk("tx_valid", bus.tx_valid, int'(mq.size() != 0));
            chk("busy", busy, int'(mq.size() != 0));
            chk("overrun", overrun, m_ov);
            if (mq.size() != 0) chk("tx_data", bus.tx_data, mq[0]);
        end
        if (!reset && bus.tx_valid && bus.tx_ready) begin
            acc.push_back(bus.tx_data);
            acc_c.push_back(cyc);
        end
        if (overrun) ov_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_tick(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("tick_timeout", 0, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic clear_acc();
        acc.delete();
        acc_c.delete();
    endtask

    function automatic int acc_at(int i);
        return i < acc.size() ? int'(acc[i]) : -1;
    endfunction

    function automatic int accc_at(int i);
        return i < acc_c.size() ? acc_c[i] : -1;
    endfunction

    initial begin
        int tk[$];
        int c, t1, t2;
        bus.tx_ready = 1'b0;
        step(3);
        run   = 1'b1;
        reset = 1'b0;
        // Idle prescaler: ticks on 8th and 16th cycle, no frames
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick) tk.push_back(i);
            chk("idle_valid", bus.tx_valid, 0);
        end
        step(1);
        chk("tick_count", tk.size(), 2);
        chk("tick_first", tk.size() > 0 ? tk[0] : -1, 7);
        chk("tick_second", tk.size() > 1 ? tk[1] : -1, 15);

        // Requested frame at full rate; sec change mid-frame must not leak in
        sec_i = 5; min_i = 10; hour_i = 3; day_i = 7; month_i = 2;
        bus.tx_ready = 1'b1;
        clear_acc();
        c   = cyc;
        req = 1'b1;
        step(1);
        req   = 1'b0;
        sec_i = 9;
        step(20);
        sec_i = 5;
        chk("f1_len", acc.size(), FRAME_LEN);
        for (int i = 0; i < FRAME_LEN; i++) chk($sformatf("f1_byte%0d", i), acc_at(i), ref1[i]);
        chk("f1_start", accc_at(0), c + 1);
        chk("f1_rate", accc_at(FRAME_LEN - 1) - accc_at(0), FRAME_LEN - 1);

        // Back-pressure on byte 2
        clear_acc();
        req = 1'b1;
        step(1);
        req = 1'b0;
        step(2);
        bus.tx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_data", bus.tx_data, 8'h07);
            chk("stall_valid", bus.tx_valid, 1);
            step(1);
        end
        bus.tx_ready = 1'b1;
        step(20);
        chk("f2_len", acc.size(), FRAME_LEN);
        for (int i = 0; i < FRAME_LEN; i++) chk($sformatf("f2_byte%0d", i), acc_at(i), ref1[i]);

        // Two requests during a frame: one queued, one dropped
        clear_acc();
        ov_cnt = 0;
        req = 1'b1;
        step(1);
        req = 1'b0;
        step(1);
        req = 1'b1;
        step(2);
        req = 1'b0;
        step(25);
        chk("ovr_pulses", ov_cnt, 1);
        chk("ovr_bytes", acc.size(), 2 * FRAME_LEN);
        chk("ovr_gap", accc_at(FRAME_LEN) - accc_at(FRAME_LEN - 1), 2);
        for (int i = 0; i < FRAME_LEN; i++) chk($sformatf("ovr_byte%0d", i), acc_at(FRAME_LEN + i), ref1[i]);

        // Reset after byte 2 accepted
        clear_acc();
        req = 1'b1;
        step(1);
        req = 1'b0;
        step(3);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid", bus.tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bytes", acc.size(), 3);
        step(2);
        reset = 1'b0;
        clear_acc();
        step(12);
        chk("post_rst_bytes", acc.size(), 0);

        // Periodic reports, fields advance after each tick
        sec_i = 20; min_i = 30; hour_i = 12; day_i = 15; month_i = 6;
        report_en = 1'b1;
        wait_tick(t1);
        sec_i = 21;
        wait_tick(t2);
        report_en = 1'b0;
        step(12);
        chk("rep_bytes", acc.size(), 2 * FRAME_LEN);
        chk("rep_start1", accc_at(0), t1 + 1);
        chk("rep_start2", accc_at(FRAME_LEN), t2 + 1);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk($sformatf("rep1_byte%0d", i), acc_at(i), ref2[i]);
            chk($sformatf("rep2_byte%0d", i), acc_at(FRAME_LEN + i), ref3[i]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
